// File: rtl/demux_sched.sv
// ---------------------------------------------------------------------------
// demux_sched
//
// Sequencer for a 1-to-4 demultiplexer datapath. Words arrive on a single
// valid/ready stream. Each word is held on a shared output bus and steered to
// one of four lanes through the demux select s and a one-hot valid strobe.
// The lane is either the next enabled lane in round-robin order, or the lane
// named by the requester in addressed mode. An addressed word that targets a
// disabled lane is swallowed and flagged with a one-cycle drop pulse.
// Completed lane transfers are counted in a wrapping counter.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous, active-high reset
//   d        in   [W-1:0] input data word
//   d_valid  in   input word present
//   d_ready  out  block can accept a word this cycle (combinational)
//   addr     in   [1:0] target lane in addressed mode
//   mode     in   0 = round-robin, 1 = addressed
//   en       in   [3:0] lane enable mask
//   y        out  [W-1:0] word presented on the shared lane bus (registered)
//   y_valid  out  [3:0] one-hot lane strobe (registered)
//   y_ready  in   [3:0] per-lane ready
//   s        out  [1:0] demux select of the held lane (registered)
//   drop     out  one-cycle pulse when an addressed word hits a disabled lane
//   xfer_cnt out  [CW-1:0] completed lane transfers, wrapping
// ---------------------------------------------------------------------------
module demux_sched #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  d,
  input  logic          d_valid,
  output logic          d_ready,
  input  logic [1:0]    addr,
  input  logic          mode,
  input  logic [3:0]    en,
  output logic [W-1:0]  y,
  output logic [3:0]    y_valid,
  input  logic [3:0]    y_ready,
  output logic [1:0]    s,
  output logic          drop,
  output logic [CW-1:0] xfer_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q;
  logic [1:0]    ptr_q;
  logic [1:0]    s_q;
  logic [W-1:0]  y_q;
  logic [3:0]    y_valid_q;
  logic          drop_q;
  logic [CW-1:0] xfer_cnt_q;

  logic [1:0]    ptr_d;
  logic [CW-1:0] xfer_cnt_d;
  logic          drop_d;

  logic          xfer;
  logic          lane_ok;
  logic          accept;
  logic [3:0]    en_rot;
  logic [1:0]    rr_ofs;
  logic          rr_hit;
  logic [1:0]    rr_k;
  logic [1:0]    tgt_k;
  logic          tgt_en;
  logic          load;

  // Output transfer: only the ready bit of the held lane matters.
  assign xfer    = (state_q == HOLD) && y_ready[s_q];

  // In round-robin mode with no enabled lane there is nowhere to send a word,
  // so the input is stalled. Addressed mode always accepts (it may drop).
  assign lane_ok = mode || (en != 4'b0000);

  assign d_ready = ((state_q == IDLE) || xfer) && lane_ok;
  assign accept  = d_valid && d_ready;

  // Enable mask rotated so that bit 0 corresponds to the lane at ptr_q.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    localparam logic [1:0] OFS = 2'(gi);
    logic [1:0] lane_idx;
    assign lane_idx   = ptr_q + OFS;
    assign en_rot[gi] = en[lane_idx];
  end

  // Lowest set bit of the rotated mask = first enabled lane at or after ptr.
  always_comb begin
    rr_ofs = 2'd0;
    rr_hit = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (en_rot[i]) begin
        rr_ofs = 2'(i);
        rr_hit = 1'b1;
      end
    end
  end

  assign rr_k   = ptr_q + rr_ofs;
  assign tgt_k  = mode ? addr : rr_k;
  // In round-robin mode a hit always exists when accepting, since d_ready
  // requires a non-zero mask; a miss can only come from addressed mode.
  assign tgt_en = mode ? en[addr] : rr_hit;
  assign load   = accept && tgt_en;

  assign drop_d     = accept && !tgt_en;
  assign ptr_d      = (accept && !mode) ? (rr_k + 2'd1) : ptr_q;
  assign xfer_cnt_d = xfer ? (xfer_cnt_q + 1'b1) : xfer_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      s_q        <= 2'd0;
      y_q        <= '0;
      y_valid_q  <= 4'b0000;
      drop_q     <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      drop_q     <= drop_d;
      xfer_cnt_q <= xfer_cnt_d;
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q   <= HOLD;
            y_q       <= d;
            s_q       <= tgt_k;
            y_valid_q <= 4'b0001 << tgt_k;
          end
        end
        HOLD: begin
          // Without a transfer everything stays frozen, whatever happens to
          // mode/en/addr; the held word was committed at accept time.
          if (xfer) begin
            if (load) begin
              y_q       <= d;
              s_q       <= tgt_k;
              y_valid_q <= 4'b0001 << tgt_k;
            end else begin
              // Either no new word, or the new word was dropped.
              state_q   <= IDLE;
              y_valid_q <= 4'b0000;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          y_valid_q <= 4'b0000;
        end
      endcase
    end
  end

  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign s        = s_q;
  assign drop     = drop_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_demux_sched.sv
module tb_demux_sched;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic       d_valid;
  logic       d_ready;
  logic [1:0] addr;
  logic       mode;
  logic [3:0] en;
  logic [7:0] y;
  logic [3:0] y_valid;
  logic [3:0] y_ready;
  logic [1:0] s;
  logic       drop;
  logic [7:0] xfer_cnt;

  int n_vec;
  int n_miss;

  demux_sched #(.W(8), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .addr     (addr),
    .mode     (mode),
    .en       (en),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .s        (s),
    .drop     (drop),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       dv;
    logic [1:0] addr;
    logic       mode;
    logic [3:0] en;
    logic [3:0] yr;
    logic       e_rdy;   // d_ready before the edge
    logic [7:0] e_y;     // after the edge
    logic [3:0] e_yv;
    logic [1:0] e_s;
    logic       e_drop;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic vec_t mk(logic [7:0] vd, logic vdv, logic [1:0] va, logic vm,
                              logic [3:0] ve, logic [3:0] vyr, logic rdy,
                              logic [7:0] ey, logic [3:0] eyv, logic [1:0] es,
                              logic edr, logic [7:0] ec);
    vec_t v;
    v.d = vd; v.dv = vdv; v.addr = va; v.mode = vm; v.en = ve; v.yr = vyr;
    v.e_rdy = rdy; v.e_y = ey; v.e_yv = eyv; v.e_s = es; v.e_drop = edr; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    //            d     dv addr m  en       yr       rdy  y     yv       s  drop cnt
    // round-robin, all lanes ready, back-to-back words
    tbl[0]  = mk(8'h10, 1, 0, 0, 4'b1111, 4'b1111, 1, 8'h10, 4'b0001, 0, 0, 0);
    tbl[1]  = mk(8'h11, 1, 0, 0, 4'b1111, 4'b1111, 1, 8'h11, 4'b0010, 1, 0, 1);
    tbl[2]  = mk(8'h12, 1, 0, 0, 4'b1111, 4'b1111, 1, 8'h12, 4'b0100, 2, 0, 2);
    tbl[3]  = mk(8'h13, 1, 0, 0, 4'b1111, 4'b1111, 1, 8'h13, 4'b1000, 3, 0, 3);
    tbl[4]  = mk(8'h14, 1, 0, 0, 4'b1111, 4'b1111, 1, 8'h14, 4'b0001, 0, 0, 4);
    tbl[5]  = mk(8'h00, 0, 0, 0, 4'b1111, 4'b1111, 1, 8'h14, 4'b0000, 0, 0, 5);
    // round-robin skip over en=1010, ptr starts at 1
    tbl[6]  = mk(8'h20, 1, 0, 0, 4'b1010, 4'b1111, 1, 8'h20, 4'b0010, 1, 0, 5);
    tbl[7]  = mk(8'h21, 1, 0, 0, 4'b1010, 4'b1111, 1, 8'h21, 4'b1000, 3, 0, 6);
    tbl[8]  = mk(8'h22, 1, 0, 0, 4'b1010, 4'b1111, 1, 8'h22, 4'b0010, 1, 0, 7);
    tbl[9]  = mk(8'h23, 1, 0, 0, 4'b1010, 4'b1111, 1, 8'h23, 4'b1000, 3, 0, 8);
    // en=0 in round-robin: no accept, held word still drains
    tbl[10] = mk(8'h24, 1, 0, 0, 4'b0000, 4'b1111, 0, 8'h23, 4'b0000, 3, 0, 9);
    tbl[11] = mk(8'h25, 1, 0, 0, 4'b0000, 4'b1111, 0, 8'h23, 4'b0000, 3, 0, 9);
    // addressed backpressure on lane 2; other lanes' ready ignored, en change ignored
    tbl[12] = mk(8'h5A, 1, 2, 1, 4'b1111, 4'b0000, 1, 8'h5A, 4'b0100, 2, 0, 9);
    tbl[13] = mk(8'h5B, 1, 2, 1, 4'b1111, 4'b1011, 0, 8'h5A, 4'b0100, 2, 0, 9);
    tbl[14] = mk(8'h5B, 1, 2, 1, 4'b1011, 4'b1011, 0, 8'h5A, 4'b0100, 2, 0, 9);
    tbl[15] = mk(8'h5B, 1, 2, 1, 4'b1111, 4'b1011, 0, 8'h5A, 4'b0100, 2, 0, 9);
    tbl[16] = mk(8'h00, 0, 2, 1, 4'b1111, 4'b0100, 1, 8'h5A, 4'b0000, 2, 0, 10);
    // addressed drop from IDLE
    tbl[17] = mk(8'hFF, 1, 0, 1, 4'b1110, 4'b0000, 1, 8'h5A, 4'b0000, 2, 1, 10);
    tbl[18] = mk(8'h00, 0, 0, 1, 4'b1110, 4'b0000, 1, 8'h5A, 4'b0000, 2, 0, 10);
    // drop coinciding with a transfer from HOLD
    tbl[19] = mk(8'h30, 1, 1, 1, 4'b1110, 4'b0000, 1, 8'h30, 4'b0010, 1, 0, 10);
    tbl[20] = mk(8'h31, 1, 0, 1, 4'b1110, 4'b0010, 1, 8'h30, 4'b0000, 1, 1, 11);
    tbl[21] = mk(8'h00, 0, 0, 1, 4'b1110, 4'b0000, 1, 8'h30, 4'b0000, 1, 0, 11);
    // addressed mode left ptr at 0
    tbl[22] = mk(8'h40, 1, 3, 0, 4'b1111, 4'b0000, 1, 8'h40, 4'b0001, 0, 0, 11);
    tbl[23] = mk(8'h00, 0, 3, 0, 4'b1111, 4'b1111, 1, 8'h40, 4'b0000, 0, 0, 12);

    // ---- reset state (asynchronous, no clock edge needed) ----
    rst = 1'b1; d = 8'h00; d_valid = 1'b0; addr = 2'd0; mode = 1'b0;
    en = 4'b1111; y_ready = 4'b0000;
    #1;
    chk("rst_y_valid", 32'(y_valid), 32'h0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_drop", 32'(drop), 32'h0);
    chk("rst_rdy_rr_en", 32'(d_ready), 32'h1);
    en = 4'b0000; #1;
    chk("rst_rdy_rr_en0", 32'(d_ready), 32'h0);
    mode = 1'b1; #1;
    chk("rst_rdy_addr_en0", 32'(d_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      d = tbl[i].d; d_valid = tbl[i].dv; addr = tbl[i].addr; mode = tbl[i].mode;
      en = tbl[i].en; y_ready = tbl[i].yr;
      #1;
      chk($sformatf("v%0d_d_ready", i), 32'(d_ready), 32'(tbl[i].e_rdy));
      @(posedge clk); #1;
      $display("vec %0d: d=%02h dv=%0b m=%0b en=%b yr=%b -> y=%02h yv=%b s=%0d drop=%0b cnt=%0d",
               i, tbl[i].d, tbl[i].dv, tbl[i].mode, tbl[i].en, tbl[i].yr,
               y, y_valid, s, drop, xfer_cnt);
      chk($sformatf("v%0d_y_valid", i), 32'(y_valid), 32'(tbl[i].e_yv));
      chk($sformatf("v%0d_s", i), 32'(s), 32'(tbl[i].e_s));
      chk($sformatf("v%0d_y", i), 32'(y), 32'(tbl[i].e_y));
      chk($sformatf("v%0d_drop", i), 32'(drop), 32'(tbl[i].e_drop));
      chk($sformatf("v%0d_xfer_cnt", i), 32'(xfer_cnt), 32'(tbl[i].e_cnt));
      @(negedge clk);
    end

    // ---- reset mid-HOLD: ptr is 1 here, lane 2 holds 0xA5 ----
    d = 8'hA5; d_valid = 1'b1; addr = 2'd2; mode = 1'b1; en = 4'b1111; y_ready = 4'b0000;
    @(posedge clk); #1;
    d_valid = 1'b0;
    chk("hold_a5_y_valid", 32'(y_valid), 32'h4);
    chk("hold_a5_y", 32'(y), 32'hA5);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset mid-HOLD: y_valid=%b cnt=%0d y=%02h s=%0d", y_valid, xfer_cnt, y, s);
    chk("midrst_y_valid", 32'(y_valid), 32'h0);
    chk("midrst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    chk("midrst_y", 32'(y), 32'h0);
    chk("midrst_s", 32'(s), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // ptr cleared: round-robin with all lanes enabled picks lane 0
    d = 8'h77; d_valid = 1'b1; mode = 1'b0; en = 4'b1111; y_ready = 4'b0000;
    @(posedge clk); #1;
    d_valid = 1'b0;
    chk("midrst_ptr_s", 32'(s), 32'h0);
    chk("midrst_ptr_y_valid", 32'(y_valid), 32'h1);

    // ---- counter wrap ----
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d_valid = 1'b1; mode = 1'b0; en = 4'b1111; y_ready = 4'b1111;
    // edge j completes j-1 transfers (the first edge only accepts)
    for (int j = 1; j <= 257; j++) begin
      d = 8'(j);
      @(posedge clk); #1;
      if (j == 256) begin
        $display("after transfer 255: cnt=%0d", xfer_cnt);
        chk("wrap_cnt_255", 32'(xfer_cnt), 32'd255);
      end
      if (j == 257) begin
        $display("after transfer 256: cnt=%0d", xfer_cnt);
        chk("wrap_cnt_0", 32'(xfer_cnt), 32'd0);
        chk("wrap_s", 32'(s), 32'(2'(j - 1)));
      end
      @(negedge clk);
    end
    d_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
